// File: rtl/capture_ctl_if.sv
// Sample stream bundle between capture stages.
// master drives data/valid/last, slave drives ready.
interface capture_ctl_if #(
  parameter int SDW = 32
);
  logic           tvalid;
  logic           tready;
  logic [SDW-1:0] tdata;
  logic           tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/capture_ctl.sv
// Capture sequencer: arm, trigger, post-trigger count, tlast, done.
// Define CAPTURE_CTL_PRETRIG_EN to forward pre-trigger samples while armed.
module capture_ctl #(
  parameter int SDW = 32,
  parameter int CW  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_wr,
  input  logic [31:0]  cfg_data,
  input  logic         ctl_arm,
  input  logic         ctl_run,
  input  logic         ctl_finish,
  capture_ctl_if.slave  sti,
  capture_ctl_if.master sto,
  output logic         indicator_arm,
  output logic         indicator_trg,
  output logic         sts_done
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    POST,
    DONE
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t         state;
  logic [CW-1:0]  dly;
  logic [CW-1:0]  cnt;
  logic           fin_pend;
  logic           vld;
  logic           last;
  logic [SDW-1:0] data;

  logic free;
  logic fin_now;
  logic rdy;
  logic acc;
  logic fwd;
  logic lst;

  if (CW < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^cfg_data[31:CW];
  end

  assign free    = !vld | sto.tready;
  assign fin_now = fin_pend | ctl_finish;
  assign acc     = sti.tvalid & rdy;

  assign sti.tready = rdy;
  assign sto.tvalid = vld;
  assign sto.tdata  = data;
  assign sto.tlast  = last;

  always_comb begin
    rdy = 1'b1;
    unique case (state)
      IDLE:  rdy = 1'b1;
`ifdef CAPTURE_CTL_PRETRIG_EN
      ARMED: rdy = free;
`else
      // Discarding path never backpressures.
      ARMED: rdy = (ctl_run | fin_now) ? free : 1'b1;
`endif
      POST:  rdy = free;
      DONE:  rdy = 1'b0;
    endcase
  end

  always_comb begin
    fwd = 1'b0;
    lst = 1'b0;
    unique case (state)
      ARMED: begin
`ifdef CAPTURE_CTL_PRETRIG_EN
        fwd = acc;
`else
        fwd = acc & (fin_now | ctl_run);
`endif
        lst = fin_now | (ctl_run & (dly == '0));
      end
      POST: begin
        fwd = acc;
        lst = fin_now | (cnt == '0);
      end
      default: begin
        fwd = 1'b0;
        lst = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dly           <= '0;
      cnt           <= '0;
      fin_pend      <= 1'b0;
      vld           <= 1'b0;
      last          <= 1'b0;
      data          <= '0;
      indicator_arm <= 1'b0;
      indicator_trg <= 1'b0;
      sts_done      <= 1'b0;
    end else begin
      sts_done <= 1'b0;
      if (cfg_wr) dly <= cfg_data[CW-1:0];

      if (fwd) begin
        vld  <= 1'b1;
        data <= sti.tdata;
        last <= lst;
      end else if (sto.tready) begin
        vld  <= 1'b0;
        last <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (ctl_arm) begin
            state         <= ARMED;
            fin_pend      <= 1'b0;
            indicator_arm <= 1'b1;
            indicator_trg <= 1'b0;
          end
        end
        ARMED: begin
          if (acc & fin_now) begin
            state         <= DONE;
            fin_pend      <= 1'b0;
            indicator_arm <= 1'b0;
          end else if (acc & ctl_run) begin
            indicator_arm <= 1'b0;
            indicator_trg <= 1'b1;
            if (dly == '0) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              state <= POST;
              cnt   <= dly - ONE;
            end
          end else if (ctl_finish) begin
            fin_pend <= 1'b1;
          end
        end
        POST: begin
          if (acc) begin
            if (fin_now | (cnt == '0)) begin
              state    <= DONE;
              fin_pend <= 1'b0;
            end else begin
              cnt <= cnt - ONE;
            end
          end else if (ctl_finish) begin
            fin_pend <= 1'b1;
          end
        end
        DONE: begin
          // tlast beat is still in the output register here.
          if (free) begin
            state    <= IDLE;
            sts_done <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
